cat_cmd_uart_tx: RTL and testbench
==================================

// Module: cat_cmd_uart_tx
// PURPOSE
//   Sending end of the inter-badge cat command link. Encodes set/clear requests for cat bits 0..7
//   as single ASCII bytes: clear = 'A'+idx (8'h41..8'h48), set = 'a'+idx (8'h61..8'h68).
//   Queues the bytes in a small FIFO and serializes them as 8N1 UART on tx.
//   Drives the interconnect TX pin in MODE_UART so a peer badge's cat_status follows this badge.
// PARAMETERS
//   CLK_FREQ    103_340_000  system clock frequency in Hz
//   BAUD        9600         line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be >= 2
//   FIFO_DEPTH  4            command queue entries; power of two, >= 2
// PORTS
//   clk        in   1  system clock; all logic on rising edge
//   reset      in   1  synchronous, active-high reset
//   cmd_valid  in   1  command request
//   cmd_ready  out  1  queue can accept; command is accepted on a cycle where cmd_valid && cmd_ready
//   cmd_idx    in   3  cat index 0..7
//   cmd_set    in   1  1 = set the bit (lowercase byte), 0 = clear the bit (uppercase byte)
//   tx         out  1  UART line; idles high
//   busy       out  1  high while a frame is on the line or the queue is non-empty
//   shadow     out  8  mirror of the remote cat_status; present only with CAT_TX_SHADOW_EN
// BEHAVIOUR
//   Reset (sync): tx=1, busy=0, cmd_ready=1, FIFO empty, FSM=IDLE, baud counter=0, shadow=8'hFF.
//     Reset asserted mid-frame abandons the frame; tx is 1 after that edge. No partial stop bit is sent.
//   Encoding at accept: byte = cmd_set ? 8'h61+cmd_idx : 8'h41+cmd_idx. Computed as 8-bit values; no wrap is possible.
//   cmd_ready = !full, registered-state based. When full, ready stays low even on a pop cycle (no same-cycle bypass).
//     cmd_valid while !cmd_ready is ignored: nothing is stored and no error flag is raised.
//   FIFO: wr/rd pointers are log2(FIFO_DEPTH)+1 bits.
//     Empty when the pointers are equal; full when the MSBs differ and the rest are equal.
//     Pointers wrap modulo 2*FIFO_DEPTH.
//   FSM states: IDLE, START, DATA, STOP.
//     IDLE : tx=1. If FIFO non-empty: pop the head into the shift register, bit_cnt=0, baud counter=0, go to START.
//     START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
//     DATA : tx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles. Shift right and bit_cnt++ after each bit.
//            Go to STOP after bit 7.
//     STOP : tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
//   tx is driven from a register (glitch-free).
//   Latency: a command accepted at edge N into an empty idle block sees IDLE pop at edge N+1.
//     tx falls after edge N+1.
//   Back-to-back: exactly one extra idle-high cycle (the IDLE visit) between the stop bit and the next start bit.
//     Frame period = 10*CLKS_PER_BIT + 1 cycles.
//   busy = (state != IDLE) || !empty.
//   Push and pop in the same cycle are both performed; occupancy is unchanged.
// CONFIGURATION
//   CAT_TX_SHADOW_EN defined: shadow[7:0] is a registered mirror of the receiver's cat_status.
//     Updated when the byte is popped (IDLE->START): bit idx <= cmd_set.
//     Reset value 8'hFF, matching the receiver's power-up value.
//   CAT_TX_SHADOW_EN undefined: no shadow port, no shadow logic. All other behaviour is identical.
// TESTING  (bench: CLK_FREQ=16, BAUD=1 -> CLKS_PER_BIT=16, FIFO_DEPTH=4)
//   1. Reset, then accept idx=2, set=0. Expected serial sequence on tx:
//      low for 16 cycles, then data bits 1,1,0,0,0,0,1,0 (8'h43 'C', LSB first), 16 cycles each,
//      then high for 16 cycles; busy drops one cycle after the stop bit.
//   2. Accept idx=7, set=1 -> byte 8'h68 'h' decoded from tx; first falling edge 1 cycle after the accept edge.
//   3. Hold cmd_valid with five distinct cmds while idle: first pops, next 4 fill the FIFO.
//      cmd_ready drops after the 5th accept; a 6th request is ignored; exactly 5 bytes go out, in order.
//      Frame starts are 161 cycles apart.
//   4. Assert reset for 1 cycle at cycle 40 of a frame: tx=1 on the next cycle, busy=0, queued bytes are discarded,
//      and no further frames are sent.
//   5. Push the last free slot on the same cycle IDLE pops: both occur, and occupancy is unchanged.
//   6. CAT_TX_SHADOW_EN: send clear idx0, clear idx5, set idx0 -> shadow goes FF -> FE -> DE -> DF,
//      each change at its pop edge.

Source files
------------

// File: rtl/cat_cmd_uart_tx_if.sv
// Command handshake between a cat-bit requester and cat_cmd_uart_tx.
// Handshake: a command transfers on every rising clk edge where cmd_valid && cmd_ready;
// the master holds cmd_idx/cmd_set stable while cmd_valid is high and not yet accepted,
// and cmd_ready never depends combinationally on cmd_valid.
interface cat_cmd_uart_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_idx;
  logic       cmd_set;

  modport master (
    output cmd_valid,
    output cmd_idx,
    output cmd_set,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_idx,
    input  cmd_set,
    output cmd_ready
  );
endinterface

// File: rtl/cat_cmd_uart_tx.sv
// cat_cmd_uart_tx: sending end of the inter-badge cat command link.
// Each set/clear request for cat bit 0..7 becomes one ASCII byte
// ('A'+idx to clear, 'a'+idx to set), is queued in a small FIFO and is
// sent as 8N1 UART on tx (idle high, LSB first).
// Optional feature macro: CAT_TX_SHADOW_EN adds the 'shadow' output, a
// mirror of the peer's cat_status updated whenever a byte leaves the queue.
module cat_cmd_uart_tx #(
  parameter int CLK_FREQ   = 103_340_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  cat_cmd_uart_tx_if.slave   cmd,
  output logic               tx,
  output logic               busy,
`ifdef CAT_TX_SHADOW_EN
  output logic [7:0]         shadow,
`endif
  output logic [1:0]         dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int PW           = AW + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [7:0]      enc_byte;
  logic [7:0]      head;
  logic            bit_done;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready comes only from registered pointers: a pop in the same cycle
  // does not open a slot for the requester.
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign pop           = (state == S_IDLE) && !empty;

  assign enc_byte = cmd.cmd_set ? (8'h61 + {5'd0, cmd.cmd_idx})
                                : (8'h41 + {5'd0, cmd.cmd_idx});
  assign head     = mem[rd_ptr[AW-1:0]];
  assign bit_done = (baud_cnt == BAUD_LAST);

  assign busy      = (state != S_IDLE) || !empty;
  assign dbg_state = state;

  // Queue storage: written on accept; contents need no reset because the
  // pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= enc_byte;
    end
  end

  // Queue pointers: push and pop may both happen in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Serializer FSM with registered tx: start, 8 data bits LSB first, stop,
  // then one IDLE cycle that pops the next byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift    <= head;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

`ifdef CAT_TX_SHADOW_EN
  // The byte alone identifies the command: bit 5 is the set flag and the
  // low three bits minus one give the index ('A'/'a' end in 3'b001).
  logic [2:0] pop_idx;
  logic       pop_set;
  assign pop_idx = head[2:0] - 3'd1;
  assign pop_set = head[5];

  // Mirror of the peer's cat_status, updated as each byte leaves the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= 8'hFF;
    end else if (pop) begin
      shadow[pop_idx] <= pop_set;
    end
  end
`endif

endmodule

// File: tb/tb_cat_cmd_uart_tx.sv
// Testbench for cat_cmd_uart_tx (CLKS_PER_BIT = 16, FIFO_DEPTH = 4).
// A frame-level model predicts tx/busy/cmd_ready (and shadow when
// CAT_TX_SHADOW_EN is defined) every cycle; a bench-side UART receiver
// decodes tx so directed tests can pin bytes and timing to literal values.
module tb_cat_cmd_uart_tx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic busy;
  logic [1:0] dbg_state;
`ifdef CAT_TX_SHADOW_EN
  logic [7:0] shadow;
`endif

  always #5 clk = ~clk;

  cat_cmd_uart_tx_if cmd_if();

  cat_cmd_uart_tx #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd_if),
    .tx       (tx),
    .busy     (busy),
`ifdef CAT_TX_SHADOW_EN
    .shadow   (shadow),
`endif
    .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  // Queue entries are {set, idx}; the line is either idle (m_pos < 0) or
  // m_pos cycles into a 10-bit frame of the current byte.
  logic [3:0] m_q[$];
  logic [3:0] m_cur = 4'd0;
  int         m_pos = -1;
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] m_shadow = 8'hFF;
  bit         m_acc;
  bit         rst_evt = 1'b0;

  function automatic logic [7:0] enc(input logic [3:0] c);
    return c[3] ? (8'h61 + {5'd0, c[2:0]}) : (8'h41 + {5'd0, c[2:0]});
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    int k;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_q.delete();
      m_pos    = -1;
      m_shadow = 8'hFF;
      rst_evt  = 1'b1;
    end else begin
      m_acc = cmd_if.cmd_valid && (m_q.size() < DEPTH);
      if (m_pos < 0) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_pos = 0;
          m_shadow[m_cur[2:0]] = m_cur[3];
        end
      end else begin
        m_pos++;
        if (m_pos == FRAME) m_pos = -1;
      end
      if (m_acc) m_q.push_back({cmd_if.cmd_set, cmd_if.cmd_idx});
    end
    m_tx    = (m_pos < 0) ? 1'b1 : frame_bit(enc(m_cur), m_pos);
    m_busy  = (m_pos >= 0) || (m_q.size() > 0);
    m_ready = (m_q.size() < DEPTH);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx", tx, m_tx);
      check("model_busy", busy, m_busy);
      check("model_ready", cmd_if.cmd_ready, m_ready);
`ifdef CAT_TX_SHADOW_EN
      check("model_shadow", shadow, m_shadow);
`endif
    end
  end

  // ---------------- line receiver ----------------
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_t0 = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_bytes[$];
  int         rx_starts[$];

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst_evt) begin
        rx_act  = 1'b0;
        rst_evt = 1'b0;
      end
      if (!rx_act) begin
        if (tx === 1'b0) begin
          rx_act = 1'b1;
          rx_cnt = 0;
          rx_t0  = cyc;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
            rx_sh[rx_cnt / CPB - 1] = tx;
          end else if (rx_cnt / CPB == 9) begin
            check("rx_stop_bit", tx, 1'b1);
            rx_bytes.push_back(rx_sh);
            rx_starts.push_back(rx_t0);
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One call = one clock cycle; inputs change at the falling edge.
  task automatic step(input bit v, input logic [2:0] idx, input bit s);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_idx   = idx;
    cmd_if.cmd_set   = s;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0);
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 2000; i++) begin
      if (!busy && tx === 1'b1 && !rx_act) break;
      step(1'b0, 3'd0, 1'b0);
    end
    check("quiet_timeout", busy, 1'b0);
  endtask

  task automatic clear_rx();
    rx_bytes.delete();
    rx_starts.delete();
  endtask

  // ---------------- directed tests ----------------
  int a;
  logic [7:0] exp3[5] = '{8'h41, 8'h64, 8'h46, 8'h62, 8'h67};
  logic [7:0] exp5[6] = '{8'h61, 8'h63, 8'h65, 8'h47, 8'h48, 8'h44};

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_idx   = 3'd0;
    cmd_if.cmd_set   = 1'b0;
    reset            = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", cmd_if.cmd_ready, 1'b1);
`ifdef CAT_TX_SHADOW_EN
    check("reset_shadow", shadow, 8'hFF);
`endif

    // Test 1: clear idx 2 -> 'C' (8'h43)
    clear_rx();
    step(1'b1, 3'd2, 1'b0);
    a = cyc;
    idle(1);
    check("t1_start_first", tx, 1'b0);
    idle(15);
    check("t1_start_last", tx, 1'b0);
    idle(1);
    check("t1_bit0", tx, 1'b1);
    idle(143);
    check("t1_stop_last_tx", tx, 1'b1);
    check("t1_stop_last_busy", busy, 1'b1);
    idle(1);
    check("t1_busy_drop", busy, 1'b0);
    wait_quiet();
    check("t1_count", rx_bytes.size(), 1);
    check("t1_byte", rx_bytes[0], 8'h43);
    check("t1_start_cycle", rx_starts[0], a + 1);

    // Test 2: set idx 7 -> 'h' (8'h68)
    clear_rx();
    step(1'b1, 3'd7, 1'b1);
    a = cyc;
    step(1'b0, 3'd0, 1'b0);
    wait_quiet();
    check("t2_count", rx_bytes.size(), 1);
    check("t2_byte", rx_bytes[0], 8'h68);
    check("t2_start_cycle", rx_starts[0], a + 1);

    // Test 3: five accepts fill the queue, sixth request ignored
    clear_rx();
    step(1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd3, 1'b1);
    step(1'b1, 3'd5, 1'b0);
    step(1'b1, 3'd1, 1'b1);
    check("t3_ready_before_5th", cmd_if.cmd_ready, 1'b1);
    step(1'b1, 3'd6, 1'b1);
    check("t3_ready_low", cmd_if.cmd_ready, 1'b0);
    step(1'b1, 3'd4, 1'b0);
    check("t3_ready_still_low", cmd_if.cmd_ready, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    wait_quiet();
    check("t3_count", rx_bytes.size(), 5);
    for (int i = 0; i < 5; i++) check("t3_byte", rx_bytes[i], exp3[i]);
    for (int i = 1; i < 5; i++) check("t3_spacing", rx_starts[i] - rx_starts[i-1], FRAME + 1);

    // Test 4: reset at cycle 40 of a frame discards everything
    clear_rx();
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    step(1'b1, 3'd3, 1'b0);
    idle(37);
    reset = 1'b1;
    step(1'b0, 3'd0, 1'b0);
    reset = 1'b0;
    check("t4_tx_after_reset", tx, 1'b1);
    check("t4_busy_after_reset", busy, 1'b0);
    check("t4_ready_after_reset", cmd_if.cmd_ready, 1'b1);
    idle(400);
    check("t4_no_frames", rx_bytes.size(), 0);
    check("t4_tx_idle", tx, 1'b1);

`ifdef CAT_TX_SHADOW_EN
    // Test 6: shadow follows clear 0, clear 5, set 0 at each pop edge
    check("t6_shadow_init", shadow, 8'hFF);
    step(1'b1, 3'd0, 1'b0);
    check("t6_before_pop1", shadow, 8'hFF);
    idle(1);
    check("t6_after_pop1", shadow, 8'hFE);
    wait_quiet();
    step(1'b1, 3'd5, 1'b0);
    check("t6_before_pop2", shadow, 8'hFE);
    idle(1);
    check("t6_after_pop2", shadow, 8'hDE);
    wait_quiet();
    step(1'b1, 3'd0, 1'b1);
    check("t6_before_pop3", shadow, 8'hDE);
    idle(1);
    check("t6_after_pop3", shadow, 8'hDF);
    wait_quiet();
`endif

    // Test 5: push into the last free slot on the IDLE pop cycle
    clear_rx();
    step(1'b1, 3'd0, 1'b1);
    a = cyc;
    step(1'b1, 3'd2, 1'b1);
    step(1'b1, 3'd4, 1'b1);
    step(1'b1, 3'd6, 1'b0);
    idle(158);
    check("t5_cycle_align", cyc, a + 161);
    step(1'b1, 3'd7, 1'b0);
    check("t5_ready_after_push_pop", cmd_if.cmd_ready, 1'b1);
    check("t5_busy", busy, 1'b1);
    step(1'b1, 3'd3, 1'b0);
    check("t5_ready_full", cmd_if.cmd_ready, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    wait_quiet();
    check("t5_count", rx_bytes.size(), 6);
    for (int i = 0; i < 6; i++) check("t5_byte", rx_bytes[i], exp5[i]);
    check("t5_first_start", rx_starts[0], a + 1);
    check("t5_second_start", rx_starts[1], a + 1 + FRAME + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
